// File: rtl/mel_pkg.sv
// rtl/mel_pkg.sv - shared sizes and read FSM state type for the bit-reversal reorder buffer
package mel_pkg;

    localparam int IDX_W     = 10;
    localparam int GNUM_W    = 7;
    localparam int GROUP_LEN = 1 << IDX_W;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RUN  = 1'b1
    } rd_state_e;

endpackage

// File: rtl/bit_rev_buf_ram.sv
// rtl/bit_rev_buf_ram.sv - simple dual-port RAM, one write port, registered read port
module bit_rev_buf_ram #(
    parameter int W  = 14,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o
);

    logic [W-1:0] mem_q [2**AW];

    // Write and read ports never address the same bank in the same cycle.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/bit_reversal_buffer.sv
// rtl/bit_reversal_buffer.sv - ping-pong reorder buffer, optional framing check under BIT_REV_BUF_FRAME_CHECK_EN
module bit_reversal_buffer
    import mel_pkg::*;
#(
    parameter int I_BW = 14,
    parameter int O_BW = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    di_en,
    input  logic signed [I_BW-1:0]  data_i,
    input  logic [GNUM_W-1:0]       in_group_num,
    input  logic [IDX_W-1:0]        in_group_idx,
    output logic                    do_en,
    output logic signed [O_BW-1:0]  data_o,
    output logic [GNUM_W-1:0]       out_group_num,
    output logic [IDX_W-1:0]        out_group_idx,
    output logic                    out_group_last,
    output logic                    frame_err
);

    logic              wr_bank_q, wr_bank_d;
    logic [IDX_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [GNUM_W-1:0] wr_gnum_q, wr_gnum_d;
    logic [GNUM_W-1:0] rd_gnum_q, rd_gnum_d;
    rd_state_e         state_q, state_d;
    logic [IDX_W-1:0]  rd_addr_q, rd_addr_d;

    logic              swap;
    logic              rd_issue;
    logic              rd_last;
    logic [I_BW-1:0]   ram_rd_data;

    logic              p1_valid_q;
    logic [IDX_W-1:0]  p1_idx_q;
    logic [GNUM_W-1:0] p1_gnum_q;

    logic              do_en_q;
    logic [O_BW-1:0]   data_o_q;
    logic [GNUM_W-1:0] out_gnum_q;
    logic [IDX_W-1:0]  out_idx_q;
    logic              out_last_q;

    // Group completion is decided by the sample count, never by the index value.
    assign swap     = di_en && (wr_cnt_q == IDX_W'(GROUP_LEN - 1));
    assign rd_issue = (state_q == RD_RUN);
    assign rd_last  = rd_issue && (rd_addr_q == {IDX_W{1'b1}});

    // Write side: count samples, latch group number on the first one, flip banks on the last.
    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        wr_gnum_d = wr_gnum_q;
        rd_gnum_d = rd_gnum_q;
        if (di_en) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == '0) begin
                wr_gnum_d = in_group_num;
            end
            if (swap) begin
                wr_bank_d = ~wr_bank_q;
                wr_cnt_d  = '0;
                rd_gnum_d = wr_gnum_q;
            end
        end
    end

    // Read FSM: a swap always (re)starts the readout at address 0, so a swap
    // coinciding with the final address continues without an idle cycle.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        case (state_q)
            RD_IDLE: begin
                if (swap) begin
                    state_d   = RD_RUN;
                    rd_addr_d = '0;
                end
            end
            RD_RUN: begin
                if (swap) begin
                    state_d   = RD_RUN;
                    rd_addr_d = '0;
                end else if (rd_last) begin
                    state_d   = RD_IDLE;
                    rd_addr_d = '0;
                end else begin
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            default: begin
                state_d   = RD_IDLE;
                rd_addr_d = '0;
            end
        endcase
    end

    // Control state registers; reset aborts both write and read sides.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            wr_gnum_q <= '0;
            rd_gnum_q <= '0;
            state_q   <= RD_IDLE;
            rd_addr_q <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_gnum_q <= wr_gnum_d;
            rd_gnum_q <= rd_gnum_d;
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    bit_rev_buf_ram #(
        .W  (I_BW),
        .AW (IDX_W + 1)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (di_en),
        .wr_addr_i ({wr_bank_q, in_group_idx}),
        .wr_data_i (data_i),
        .rd_en_i   (rd_issue),
        .rd_addr_i ({~wr_bank_q, rd_addr_q}),
        .rd_data_o (ram_rd_data)
    );

    // Sideband pipeline: stage 1 aligns with the RAM read register, stage 2 drives the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_valid_q <= 1'b0;
            p1_idx_q   <= '0;
            p1_gnum_q  <= '0;
            do_en_q    <= 1'b0;
            data_o_q   <= '0;
            out_gnum_q <= '0;
            out_idx_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            p1_valid_q <= rd_issue;
            p1_idx_q   <= rd_addr_q;
            p1_gnum_q  <= rd_gnum_q;
            do_en_q    <= p1_valid_q;
            out_gnum_q <= p1_gnum_q;
            out_idx_q  <= p1_idx_q;
            out_last_q <= p1_valid_q && (p1_idx_q == {IDX_W{1'b1}});
            if (p1_valid_q) begin
                data_o_q <= O_BW'(ram_rd_data);
            end
        end
    end

    assign do_en          = do_en_q;
    assign data_o         = data_o_q;
    assign out_group_num  = out_gnum_q;
    assign out_group_idx  = out_idx_q;
    assign out_group_last = out_last_q;

`ifdef BIT_REV_BUF_FRAME_CHECK_EN
    logic frame_err_q;
    logic gnum_mismatch;
    logic swap_overrun;

    assign gnum_mismatch = di_en && (wr_cnt_q != '0) && (in_group_num != wr_gnum_q);
    assign swap_overrun  = swap && rd_issue && !rd_last;

    // Sticky framing error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else if (gnum_mismatch || swap_overrun) begin
            frame_err_q <= 1'b1;
        end
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule
